// File: rtl/expr_emitter_pkg.sv
// Shared definitions for the expression emitter.
//   ZERO/PLUS/STAR : the ASCII characters the emitter can produce
//   state_t        : one-hot emitter state encoding
package expr_emitter_pkg;

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] PLUS = 8'h2B;
    localparam logic [7:0] STAR = 8'h2A;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_DIGIT  = 4'b0010,
        S_OP     = 4'b0100,
        S_FINISH = 4'b1000
    } state_t;

endpackage

// File: rtl/expr_emitter.sv
// Serial transmitter of a digit/operator ASCII expression.
// Loads up to MAX_TERMS BCD operands and their operators in one cycle, then
// emits digit, op, digit, ... digit under a valid/ready handshake.
// Ports:
//   clk, clr  : clock, asynchronous active-high reset
//   start     : load request, honoured only in IDLE
//   nterms    : operand count (1..MAX_TERMS)
//   digits    : BCD operands, term i at [4i+3:4i]
//   ops       : operator after term i, 0='+', 1='*'
//   ready     : consumer accepts ch this cycle
//   ch        : ASCII character, qualified by ch_valid
//   busy      : emission in progress
//   done      : one-cycle pulse after the last character transfers
//   err       : one-cycle pulse on a rejected load
module expr_emitter
    import expr_emitter_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    localparam int CW = $clog2(MAX_TERMS) + 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [CW-1:0]          nterms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-1:0]   ops,
    input  logic                   ready,
    output logic [7:0]             ch,
    output logic                   ch_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int IW = CW - 1;

    state_t                 state;
    logic [4*MAX_TERMS-1:0] digits_q;
    logic [MAX_TERMS-1:0]   ops_q;
    logic [CW-1:0]          nterms_q;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          next_idx;
    logic                   load_ok;
    logic                   last_term;

    // Only terms that will actually be emitted need to be valid BCD.
    always_comb begin
        load_ok = (nterms != '0) && (nterms <= CW'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((i < int'(nterms)) && (digits[4*i +: 4] > 4'd9)) begin
                load_ok = 1'b0;
            end
        end
    end

    assign next_idx  = idx + IW'(1);
    assign last_term = ({1'b0, idx} == (nterms_q - CW'(1)));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            digits_q <= '0;
            ops_q    <= '0;
            nterms_q <= '0;
            idx      <= '0;
            ch       <= 8'h00;
            ch_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (load_ok) begin
                            digits_q <= digits;
                            ops_q    <= ops;
                            nterms_q <= nterms;
                            idx      <= '0;
                            state    <= S_DIGIT;
                            busy     <= 1'b1;
                            ch_valid <= 1'b1;
                            ch       <= ZERO + {4'h0, digits[3:0]};
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DIGIT: begin
                    if (ch_valid && ready) begin
                        if (last_term) begin
                            // done/busy change here so they line up with
                            // the FINISH cycle itself.
                            state    <= S_FINISH;
                            ch_valid <= 1'b0;
                            ch       <= 8'h00;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= S_OP;
                            ch    <= ops_q[idx] ? STAR : PLUS;
                        end
                    end
                end
                S_OP: begin
                    if (ch_valid && ready) begin
                        idx   <= next_idx;
                        state <= S_DIGIT;
                        ch    <= ZERO + {4'h0, digits_q[{next_idx, 2'b00} +: 4]};
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
